traffic_phase_ctrl: RTL and testbench
=====================================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 Parameter N_APPR, default 2: number of vehicle approaches, legal range 2..8.
REQ-002 Parameter TICK_DIV, default 16: clk cycles per timing tick, minimum 1.
REQ-003 Parameters GREEN_TICKS 10, YELLOW_TICKS 4, ALLRED_TICKS 2, WALK_TICKS 8, PCLR_TICKS 8, FLASH_TICKS 4: dwell or toggle lengths in ticks, each minimum 1.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 maint  in  1  level; 1 = maintenance flash mode.
REQ-007 ped_req  in  1  pedestrian request, any pulse width of 1 cycle or more.
REQ-008 green, yellow, red  out  N_APPR each  per-approach lamps; bit k = approach k.
REQ-009 walk, dont_walk  out  1 each  pedestrian lamps.
REQ-010 phase  out  $clog2(N_APPR)  index of the currently served approach.
REQ-011 maint_active  out  1  high while in MAINT state.

Function
REQ-012 States: GREEN, YELLOW, ALLRED, WALK, PCLR, MAINT; phase register selects the approach for GREEN and YELLOW.
REQ-013 Prescaler and dwell counter both clear on every state transition, so each state lasts exactly dur*TICK_DIV cycles.
REQ-014 Transition occurs on the edge where the prescaler is at TICK_DIV-1 and the dwell counter is at dur-1.
REQ-015 Sequence: GREEN(p) -> YELLOW(p) -> ALLRED; from ALLRED, if p<N_APPR-1 then p+1 and GREEN.
REQ-016 From ALLRED with p=N_APPR-1: if ped_pend|ped_req then WALK, else p=0 and GREEN.
REQ-017 WALK -> PCLR -> ALLRED with p held at N_APPR-1; the following ALLRED exits to p=0 GREEN, and the pedestrian check is not repeated.
REQ-018 ped_pend sets on any cycle with ped_req=1 outside WALK and clears on the WALK entry edge; a ped_req during WALK is dropped.
REQ-019 Lamps decode from registered state only; there is no combinational input-to-output path.
REQ-020 GREEN(p): green[p]=1, all other red=1. YELLOW(p): yellow[p]=1, all other red=1. ALLRED, WALK and PCLR: red all 1.
REQ-021 Exactly one of green, yellow or red is 1 per approach, in every state except MAINT.
REQ-022 walk=1 only in WALK. In PCLR, dont_walk is the flash bit. In all other non-MAINT states, dont_walk=1.
REQ-023 The flash bit toggles every FLASH_TICKS ticks and is set to 1 on entry to PCLR or MAINT.
REQ-024 maint=1 overrides every state on the next edge. MAINT drives green=yellow=0, red all = flash, dont_walk = flash, walk=0.
REQ-025 maint falling: next edge enters ALLRED with p=N_APPR-1, so service resumes at approach 0; ped_pend is retained.
REQ-026 maint and ped_req asserted in the same cycle: MAINT wins and ped_pend still sets.

Reset
REQ-027 reset=0 on a clk edge: state=GREEN, phase=0, prescaler=0, dwell=0, ped_pend=0, flash=1.
REQ-028 Resulting outputs: green=1<<0, yellow=0, red=~1, walk=0, dont_walk=1, maint_active=0.
REQ-029 Reset has priority over maint, and a mid-phase reset abandons the phase without a yellow interval.

Structure
REQ-030 Shared package traffic_pkg holds the state enum, the lamp-code constants and the counter-width function (clog2 of the maximum duration).
REQ-031 Sub-module tick_prescaler: clear input, tick output, parametrised by TICK_DIV.

Verification
REQ-032 Test configuration: N_APPR=3, TICK_DIV=4, GREEN=5, YELLOW=2, ALLRED=1, WALK=4, PCLR=4, FLASH=2 throughout.
REQ-033 Release reset, no ped_req -> green[0] for 20 cycles, yellow[0] for 8, all-red for 4, then green[1]; full cycle 96 cycles.
REQ-034 ped_req 1-cycle pulse during GREEN(1) -> after ALLRED of approach 2: walk for 16 cycles, then PCLR with dont_walk toggling every 8 cycles for 16, ALLRED 4, green[0]; cycle 132.
REQ-035 ped_req held high through WALK -> exactly one WALK, and the next cycle has no WALK.
REQ-036 maint=1 mid GREEN(1) -> next edge: red=3'b111, green=0, maint_active=1; red toggles every 8 cycles.
REQ-037 maint then dropped -> ALLRED for 4 cycles, then green[0].
REQ-038 reset=0 for 1 cycle during YELLOW(2) -> next edge green=3'b001 and no yellow is seen; maint=1 together with reset=0 -> reset values, not MAINT.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic phase controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_WALK,
    ST_PCLR,
    ST_MAINT
  } state_t;

  // Per-approach lamp code {green, yellow, red}.
  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..max_dur-1, never less than one.
  function automatic int unsigned cnt_width(int unsigned max_dur);
    return (max_dur <= 2) ? 1 : $clog2(max_dur);
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_prescaler.sv
// Divides clk down to a one-cycle timing tick every TICK_DIV cycles.
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = cnt_width(TICK_DIV);

  logic [PW-1:0] cnt;

  assign tick = (cnt == PW'(TICK_DIV - 1));

  // Free-running divider, restarted by reset or an explicit clear.
  always_ff @(posedge clk) begin
    if (!reset || clear || tick) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-approach signal sequencer with pedestrian phase and maintenance flash.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned N_APPR       = 2,
  parameter int unsigned TICK_DIV     = 16,
  parameter int unsigned GREEN_TICKS  = 10,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned WALK_TICKS   = 8,
  parameter int unsigned PCLR_TICKS   = 8,
  parameter int unsigned FLASH_TICKS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      maint,
  input  logic                      ped_req,
  output logic [N_APPR-1:0]         green,
  output logic [N_APPR-1:0]         yellow,
  output logic [N_APPR-1:0]         red,
  output logic                      walk,
  output logic                      dont_walk,
  output logic [$clog2(N_APPR)-1:0] phase,
  output logic                      maint_active
);

  localparam int unsigned PW      = $clog2(N_APPR);
  localparam int unsigned MAX_DUR = max_u(max_u(max_u(GREEN_TICKS, YELLOW_TICKS),
                                                max_u(ALLRED_TICKS, WALK_TICKS)),
                                          max_u(PCLR_TICKS, FLASH_TICKS));
  localparam int unsigned DW      = cnt_width(MAX_DUR);
  localparam logic [PW-1:0] LAST  = PW'(N_APPR - 1);

  state_t        state, state_nx;
  logic [PW-1:0] phase_q, phase_nx;
  logic [DW-1:0] dwell, fcnt, dur_m1;
  logic          skip_ped, skip_nx;
  logic          ped_pend, flash, tick, done, trans;
  logic [2:0]    lamp;

  assign trans = (state_nx != state);
  assign phase = phase_q;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .clear (trans),
    .tick  (tick)
  );

  // Dwell length of the current state, minus one.
  always_comb begin
    dur_m1 = '0;
    case (state)
      ST_GREEN:  dur_m1 = DW'(GREEN_TICKS - 1);
      ST_YELLOW: dur_m1 = DW'(YELLOW_TICKS - 1);
      ST_ALLRED: dur_m1 = DW'(ALLRED_TICKS - 1);
      ST_WALK:   dur_m1 = DW'(WALK_TICKS - 1);
      ST_PCLR:   dur_m1 = DW'(PCLR_TICKS - 1);
      default:   dur_m1 = '0;
    endcase
  end

  assign done = tick && (dwell == dur_m1);

  // State register with phase and pedestrian-skip flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_GREEN;
      phase_q  <= '0;
      skip_ped <= 1'b0;
    end else begin
      state    <= state_nx;
      phase_q  <= phase_nx;
      skip_ped <= skip_nx;
    end
  end

  // Next-state: maint overrides, maint exit parks on last approach's all-red.
  // skip_ped marks an all-red that must not re-check for pedestrians.
  always_comb begin
    state_nx = state;
    phase_nx = phase_q;
    skip_nx  = skip_ped;
    if (maint) begin
      state_nx = ST_MAINT;
    end else if (state == ST_MAINT) begin
      state_nx = ST_ALLRED;
      phase_nx = LAST;
      skip_nx  = 1'b1;
    end else if (done) begin
      case (state)
        ST_GREEN:  state_nx = ST_YELLOW;
        ST_YELLOW: begin
          state_nx = ST_ALLRED;
          skip_nx  = 1'b0;
        end
        ST_ALLRED: begin
          if (phase_q != LAST) begin
            state_nx = ST_GREEN;
            phase_nx = phase_q + 1'b1;
          end else if (!skip_ped && (ped_pend || ped_req)) begin
            state_nx = ST_WALK;
          end else begin
            state_nx = ST_GREEN;
            phase_nx = '0;
          end
        end
        ST_WALK:   state_nx = ST_PCLR;
        ST_PCLR: begin
          state_nx = ST_ALLRED;
          skip_nx  = 1'b1;
        end
        default:   state_nx = state;
      endcase
    end
  end

  // Dwell and flash counters, flash bit and pedestrian latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dwell    <= '0;
      fcnt     <= '0;
      flash    <= 1'b1;
      ped_pend <= 1'b0;
    end else begin
      if (trans) begin
        dwell <= '0;
        fcnt  <= '0;
        if (state_nx == ST_PCLR || state_nx == ST_MAINT) flash <= 1'b1;
      end else if (tick) begin
        if (state != ST_MAINT) dwell <= dwell + 1'b1;
        if (fcnt == DW'(FLASH_TICKS - 1)) begin
          fcnt  <= '0;
          flash <= ~flash;
        end else begin
          fcnt  <= fcnt + 1'b1;
        end
      end
      if (state != ST_WALK && state_nx == ST_WALK) ped_pend <= 1'b0;
      else if (state != ST_WALK && ped_req)        ped_pend <= 1'b1;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    green        = '0;
    yellow       = '0;
    red          = '0;
    walk         = 1'b0;
    dont_walk    = 1'b1;
    maint_active = 1'b0;
    lamp         = LAMP_RED;
    if (state == ST_MAINT) begin
      red          = {N_APPR{flash}};
      dont_walk    = flash;
      maint_active = 1'b1;
    end else begin
      for (int unsigned k = 0; k < N_APPR; k++) begin
        lamp = LAMP_RED;
        if (phase_q == PW'(k)) begin
          if (state == ST_GREEN)  lamp = LAMP_GREEN;
          if (state == ST_YELLOW) lamp = LAMP_YELLOW;
        end
        green[k]  = lamp[2];
        yellow[k] = lamp[1];
        red[k]    = lamp[0];
      end
      if (state == ST_WALK) begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      if (state == ST_PCLR) dont_walk = flash;
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl (3 approaches, short timings).
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset, maint, ped_req;
  logic [2:0] green, yellow, red;
  logic       walk, dont_walk, maint_active;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_phase_ctrl #(
    .N_APPR(3), .TICK_DIV(4), .GREEN_TICKS(5), .YELLOW_TICKS(2),
    .ALLRED_TICKS(1), .WALK_TICKS(4), .PCLR_TICKS(4), .FLASH_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .maint(maint), .ped_req(ped_req),
    .green(green), .yellow(yellow), .red(red), .walk(walk),
    .dont_walk(dont_walk), .phase(phase), .maint_active(maint_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        mnt;
    logic        ped;
    int          n;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  // {phase, green, yellow, red, walk, dont_walk, maint_active}
  function automatic logic [13:0] ex(logic [1:0] ph, logic [2:0] g, logic [2:0] y,
                                     logic [2:0] r, logic w, logic dw, logic ma);
    return {ph, g, y, r, w, dw, ma};
  endfunction

  function automatic vec_t mk(logic rn, logic m, logic p, int n, logic [13:0] e);
    vec_t v;
    v.rst_n = rn; v.mnt = m; v.ped = p; v.n = n; v.exp = e;
    return v;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [13:0] e);
    logic [13:0] act;
    act = {phase, green, yellow, red, walk, dont_walk, maint_active};
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got ph/g/y/r/w/dw/ma=%b expected %b", nm, act, e);
    end
  endtask

  localparam logic [13:0] G0  = {2'd0, 3'b001, 3'b000, 3'b110, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] AR2 = {2'd2, 3'b000, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0};
  localparam logic [13:0] WK2 = {2'd2, 3'b000, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0};

  initial begin
    int bad_walk;
    reset = 1'b0; maint = 1'b0; ped_req = 1'b0;

    // Plain cycle, then a pedestrian cycle started by a 1-cycle pulse.
    tbl.push_back(mk(0, 0, 0,  2, G0));
    tbl.push_back(mk(1, 0, 0, 19, G0));
    tbl.push_back(mk(1, 0, 0,  1, ex(0, 3'b000, 3'b001, 3'b110, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0,  7, ex(0, 3'b000, 3'b001, 3'b110, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0,  1, ex(0, 3'b000, 3'b000, 3'b111, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0,  3, ex(0, 3'b000, 3'b000, 3'b111, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0,  1, ex(1, 3'b010, 3'b000, 3'b101, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0, 20, ex(1, 3'b000, 3'b010, 3'b101, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0,  8, ex(1, 3'b000, 3'b000, 3'b111, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0,  4, ex(2, 3'b100, 3'b000, 3'b011, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0, 20, ex(2, 3'b000, 3'b100, 3'b011, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0,  8, AR2));
    tbl.push_back(mk(1, 0, 0,  3, AR2));
    tbl.push_back(mk(1, 0, 0,  1, G0));
    tbl.push_back(mk(1, 0, 0, 42, ex(1, 3'b010, 3'b000, 3'b101, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 1,  1, ex(1, 3'b010, 3'b000, 3'b101, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0, 53, WK2));
    tbl.push_back(mk(1, 0, 0, 15, WK2));
    tbl.push_back(mk(1, 0, 0,  1, AR2));
    tbl.push_back(mk(1, 0, 0,  7, AR2));
    tbl.push_back(mk(1, 0, 0,  1, ex(2, 3'b000, 3'b000, 3'b111, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0,  7, ex(2, 3'b000, 3'b000, 3'b111, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0,  1, AR2));
    tbl.push_back(mk(1, 0, 0,  3, AR2));
    tbl.push_back(mk(1, 0, 0,  1, G0));

    foreach (tbl[i]) begin
      reset   = tbl[i].rst_n;
      maint   = tbl[i].mnt;
      ped_req = tbl[i].ped;
      step(tbl[i].n);
      check($sformatf("row%0d", i), tbl[i].exp);
    end

    // ped_req held across the WALK entry: one WALK only, none next cycle.
    step(88);
    check("yellow2_before_hold", ex(2, 3'b000, 3'b100, 3'b011, 0, 1, 0));
    ped_req = 1'b1;
    step(10);
    check("walk_with_held_req", WK2);
    step(2);
    ped_req = 1'b0;
    step(12);
    check("pclr_after_held", AR2);
    bad_walk = 0;
    for (int i = 0; i < 116; i++) begin
      step(1);
      if (walk !== 1'b0) bad_walk++;
    end
    n_checks++;
    if (bad_walk != 0) begin
      n_fail++;
      $display("FAIL no_second_walk: got %0d walk cycles expected 0", bad_walk);
    end
    check("green0_after_no_walk", G0);

    // Maintenance entered mid GREEN(1) together with a ped_req pulse.
    step(40);
    check("green1_before_maint", ex(1, 3'b010, 3'b000, 3'b101, 0, 1, 0));
    maint = 1'b1; ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    check("maint_entry", ex(1, 3'b000, 3'b000, 3'b111, 0, 1, 1));
    step(7);
    check("maint_flash_on", ex(1, 3'b000, 3'b000, 3'b111, 0, 1, 1));
    step(1);
    check("maint_flash_off", ex(1, 3'b000, 3'b000, 3'b000, 0, 0, 1));
    step(2);
    maint = 1'b0;
    step(1);
    check("maint_exit_allred", AR2);
    step(3);
    check("maint_exit_allred_end", AR2);
    step(1);
    check("maint_exit_green0", G0);
    step(96);
    check("retained_ped_walk", WK2);
    step(36);
    check("green0_after_retained_walk", G0);

    // Reset with maint during YELLOW(2): reset wins, no yellow on approach 0.
    step(86);
    check("yellow2_before_reset", ex(2, 3'b000, 3'b100, 3'b011, 0, 1, 0));
    reset = 1'b0; maint = 1'b1;
    step(1);
    check("reset_over_maint", G0);
    reset = 1'b1; maint = 1'b0;
    step(1);
    check("post_reset_green", G0);
    step(18);
    check("post_reset_green_end", G0);
    step(1);
    check("post_reset_yellow0", ex(0, 3'b000, 3'b001, 3'b110, 0, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
